rr_select_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8-way select resource among 8 requesters.
- Produces a registered 3-bit grant address, which feeds the 3-to-8 select decoder, plus a matching one-hot grant.
- Holds each grant until the owner releases it or a hold timeout expires.
- Inserts one idle turnaround cycle between grants, so two select lines are never active back-to-back.

---
 rtl/rr_select_arbiter.sv | 97 +++++++++
 tb/tb_rr_select_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter sharing one 8-way select resource among 8 requesters.
// The grant is registered, held until release or timeout, and followed by one idle turnaround cycle.
module rr_select_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_req,
    input  logic       i_done,
    output logic       o_grant_valid,
    output logic [2:0] o_grant_addr,
    output logic [7:0] o_grant_onehot,
    output logic       o_timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit                HOLD_EN   = (MAX_HOLD > 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    state_t            state;
    logic [2:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic              found;
    logic [2:0]        winner;
    logic [2:0]        idx;
    logic              owner_done;
    logic              owner_gone;
    logic              hold_expired;
    logic              release_now;

    // Search upward from the pointer; the 3-bit sum wraps 7 back to 0.
    always_comb begin
        // NOTE: every variable gets a value before the loop so no latch is inferred.
        found  = 1'b0;
        winner = ptr;
        idx    = '0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && i_req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign owner_done   = i_done;
    assign owner_gone   = !i_req[o_grant_addr];
    assign hold_expired = HOLD_EN && (hold_cnt == HOLD_LAST);
    assign release_now  = owner_done || owner_gone || hold_expired;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            ptr            <= 3'd0;
            hold_cnt       <= '0;
            o_grant_valid  <= 1'b0;
            o_grant_addr   <= 3'd0;
            o_grant_onehot <= 8'h00;
            o_timeout      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values.
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state          <= GRANT;
                        o_grant_valid  <= 1'b1;
                        o_grant_addr   <= winner;
                        o_grant_onehot <= 8'd1 << winner;
                        hold_cnt       <= '0;
                        ptr            <= winner + 3'd1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state          <= IDLE;
                        o_grant_valid  <= 1'b0;
                        o_grant_onehot <= 8'h00;
                        hold_cnt       <= '0;
                        // A forced release only counts when the owner did not also let go.
                        o_timeout      <= hold_expired && !owner_done && !owner_gone;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Scoreboard bench for rr_select_arbiter: stimulus queues expected grants, a monitor
// checks address, length, turnaround and timeout pulse of every grant the DUT presents.
module tb_rr_select_arbiter;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_req;
    logic       i_done;
    logic       o_grant_valid;
    logic [2:0] o_grant_addr;
    logic [7:0] o_grant_onehot;
    logic       o_timeout;

    rr_select_arbiter #(.MAX_HOLD(4)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req          (i_req),
        .i_done         (i_done),
        .o_grant_valid  (o_grant_valid),
        .o_grant_addr   (o_grant_addr),
        .o_grant_onehot (o_grant_onehot),
        .o_timeout      (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // dur and gap of -1 mean "not checked" for that grant.
    typedef struct {
        logic [2:0] addr;
        int         dur;
        int         gap;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void expect_grant(input logic [2:0] a, input int d, input int g,
                                         input logic t);
        exp_t e;
        e.addr = a;
        e.dur  = d;
        e.gap  = g;
        e.to   = t;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] req);
        i_rst = 1'b1;
        i_req = req;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic wait_grant();
        int n = 0;
        @(negedge i_clk);
        while (!o_grant_valid && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("grant_seen", 32'(o_grant_valid), 32'd1);
    endtask

    task automatic wait_release();
        int n = 0;
        @(negedge i_clk);
        while (o_grant_valid && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("release_seen", 32'(o_grant_valid), 32'd0);
    endtask

    // Owner pulses i_done during the n-th grant cycle, then the request vector changes.
    task automatic serve(input int n, input logic [7:0] next_req);
        wait_grant();
        repeat (n - 1) @(negedge i_clk);
        i_done = 1'b1;
        @(posedge i_clk);
        #1;
        i_done = 1'b0;
        i_req  = next_req;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   32'(o_grant_valid),  32'd0);
        check({tag, "_addr"},    32'(o_grant_addr),   32'd0);
        check({tag, "_onehot"},  32'(o_grant_onehot), 32'd0);
        check({tag, "_timeout"}, 32'(o_timeout),      32'd0);
    endtask

    // Monitor: pops an expectation on every rising grant, checks it on the way out.
    initial begin
        exp_t cur;
        bit   have_cur   = 1'b0;
        bit   prev_valid = 1'b0;
        bit   fall;
        int   run        = 0;
        int   gap        = 0;
        forever begin
            @(negedge i_clk);
            check("onehot_decode", 32'(o_grant_onehot),
                  32'(o_grant_valid ? (8'd1 << o_grant_addr) : 8'd0));
            fall = prev_valid && !o_grant_valid;
            if (o_grant_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(o_grant_valid), 32'd0);
                    have_cur = 1'b0;
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    check("grant_addr", 32'(o_grant_addr), 32'(cur.addr));
                    if (cur.gap >= 0) check("turnaround", gap, cur.gap);
                end
                run = 1;
            end else if (o_grant_valid) begin
                run++;
            end else if (fall) begin
                if (have_cur && cur.dur >= 0) check("grant_len", run, cur.dur);
                check("timeout_pulse", 32'(o_timeout), 32'(have_cur ? cur.to : 1'b0));
                have_cur = 1'b0;
            end
            if (!fall && o_timeout) check("stray_timeout", 32'(o_timeout), 32'd0);
            if (o_grant_valid) gap = 0;
            else gap++;
            prev_valid = o_grant_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        i_rst  = 1'b1;
        i_req  = 8'hFF;
        i_done = 1'b0;

        // Reset held with every requester active.
        repeat (3) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check_reset_outputs("reset");
        end
        i_rst = 1'b0;
        expect_grant(3'd0, 2, -1, 1'b0);
        serve(2, 8'h00);
        repeat (2) tick();

        // Single requester 5: re-granted because the search wraps from 6 to 5.
        expect_grant(3'd5, 2, -1, 1'b0);
        do_reset(8'h20);
        serve(2, 8'h20);
        expect_grant(3'd5, 2, 1, 1'b0);
        serve(2, 8'h03);

        // Pointer at 6 with requests 0 and 1: skips 6,7 and wraps to 0, then 1.
        expect_grant(3'd0, 2, 1, 1'b0);
        serve(2, 8'h03);
        expect_grant(3'd1, 2, 1, 1'b0);
        serve(2, 8'h00);
        tick();

        // Full rotation with all eight requesting.
        do_reset(8'hFF);
        for (int k = 0; k < 10; k++) begin
            expect_grant(3'(k % 8), 2, (k == 0) ? -1 : 1, 1'b0);
            serve(2, (k == 9) ? 8'h00 : 8'hFF);
        end
        tick();

        // Hold timeout after 4 cycles, then done on the 4th cycle suppresses the pulse.
        i_req = 8'h08;
        expect_grant(3'd3, 4, -1, 1'b1);
        expect_grant(3'd3, 4, 1, 1'b0);
        wait_grant();
        wait_release();
        serve(4, 8'h00);
        tick();

        // Mid-grant reset; requests 2 and 7 afterwards show the pointer restarted at 0.
        i_req = 8'h04;
        expect_grant(3'd2, -1, -1, 1'b0);
        expect_grant(3'd2, 2, -1, 1'b0);
        expect_grant(3'd7, 2, 1, 1'b0);
        wait_grant();
        i_rst = 1'b1;
        i_req = 8'h84;
        tick();
        check_reset_outputs("midrst");
        i_rst = 1'b0;

        // Owner 2 withdraws in its second cycle; requester 7 waited and is served next.
        wait_grant();
        @(negedge i_clk);
        i_req = 8'h80;
        serve(2, 8'h00);
        repeat (3) tick();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
